// File: rtl/uart_rx_ram_loader.sv
// 8N1 UART receiver that pairs bytes (high byte first) into words and writes them
// to consecutive RAM addresses from 0, raising a sticky load_done after WORD_COUNT words.
module uart_rx_ram_loader #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned ADDR_W       = 6,
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned WORD_COUNT   = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              uart_rx,
    output logic              write_enable_to_ram,
    output logic [ADDR_W-1:0] address_to_ram,
    output logic [DATA_W-1:0] data_to_ram,
    output logic              load_done,
    output logic              frame_error
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORD_COUNT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StWaitIdle
    } state_e;

    state_e            state_q, state_d;
    logic              rx_meta_q, rx_sync_q;
    logic [CNT_W-1:0]  baud_q, baud_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic [7:0]        high_q, high_d;
    logic              half_q, half_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              done_q, done_d;
    logic              ferr_q, ferr_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            state_q   <= StIdle;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            high_q    <= '0;
            half_q    <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            done_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            rx_meta_q <= uart_rx;
            rx_sync_q <= rx_meta_q;
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            high_q    <= high_d;
            half_q    <= half_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            done_q    <= done_d;
            ferr_q    <= ferr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        high_d    = high_q;
        half_d    = half_q;
        we_d      = 1'b0;
        addr_d    = addr_q;
        data_d    = data_q;
        done_d    = done_q;
        ferr_d    = ferr_q;

        unique case (state_q)
            StIdle: begin
                if (!rx_sync_q) begin
                    state_d = StStart;
                    baud_d  = '0;
                end
            end
            StStart: begin
                if (baud_q == HALF_LAST) begin
                    baud_d = '0;
                    // A start bit that is high again at mid-bit is a glitch.
                    if (!rx_sync_q) begin
                        state_d   = StData;
                        bit_idx_d = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            StData: begin
                if (baud_q == BIT_LAST) begin
                    baud_d             = '0;
                    shift_d[bit_idx_q] = rx_sync_q;
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            StStop: begin
                if (baud_q == BIT_LAST) begin
                    baud_d = '0;
                    if (rx_sync_q) begin
                        state_d = StIdle;
                        if (!half_q) begin
                            high_d = shift_q;
                            half_d = 1'b1;
                        end else begin
                            half_d = 1'b0;
                            if (!done_q) begin
                                we_d   = 1'b1;
                                data_d = DATA_W'({high_q, shift_q});
                            end
                        end
                    end else begin
                        ferr_d  = 1'b1;
                        half_d  = 1'b0;
                        state_d = StWaitIdle;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            StWaitIdle: begin
                if (rx_sync_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Address advances the cycle after the strobe; the final write parks it instead.
        if (we_q) begin
            if (addr_q == LAST_ADDR) begin
                done_d = 1'b1;
            end else begin
                addr_d = addr_q + 1'b1;
            end
        end
    end

    assign write_enable_to_ram = we_q;
    assign address_to_ram      = addr_q;
    assign data_to_ram         = data_q;
    assign load_done           = done_q;
    assign frame_error         = ferr_q;

endmodule

// File: doc/uart_rx_ram_loader.md
Name: uart_rx_ram_loader

Overview:
UART receiver that loads 16-bit words into the 64×16 output-code RAM over a serial line. It is the inbound counterpart of the RAM-readout/UART-TX path. It deserialises 8N1 bytes and pairs them into words, high byte first. Each completed word is written to consecutive RAM addresses from 0 using the same write-port signalling the CPU uses. When the programmed word count is reached, it raises a sticky done flag.

Parameters:
CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); legal values ≥ 4.
ADDR_W, 6, RAM address width.
DATA_W, 16, RAM word width; fixed at 2 bytes.
WORD_COUNT, 64, words to load before load_done; 1..2^ADDR_W.

Ports:
clk  input  1  system clock.
reset  input  1  synchronous, active-low reset (0 = reset).
uart_rx  input  1  serial line, idle high, 8N1, LSB first.
write_enable_to_ram  output  1  one-cycle write strobe to RAM wea.
address_to_ram  output  ADDR_W  RAM write address.
data_to_ram  output  DATA_W  RAM write data.
load_done  output  1  sticky; WORD_COUNT words written.
frame_error  output  1  sticky; a stop bit was sampled low.

Behaviour:
- Reset state (reset==0 at posedge clk): write_enable_to_ram=0, address_to_ram=0, data_to_ram=0, load_done=0, frame_error=0. Synchroniser flops =1, FSM=IDLE, half-word flag=0, bit/baud counters=0.
- Reset has priority at every posedge. Reset mid-frame aborts the frame and discards any held high byte.
- uart_rx passes through a 2-FF synchroniser; all sampling uses the synchronised value.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: on synchronised rx==0, go to START and clear the baud counter.
  - START: after CLKS_PER_BIT/2 cycles (integer divide), resample. If 0, go to DATA with bit index 0. If 1, treat as a glitch and return to IDLE with no error.
  - DATA: every CLKS_PER_BIT cycles, sample one bit into shift-register position [bit index], LSB first. After bit 7, go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample the stop bit.
    - Stop bit 1: byte valid; go to IDLE.
    - Stop bit 0: set frame_error=1, discard the byte, clear the half-word flag, and go to WAIT_IDLE.
  - WAIT_IDLE: stay until synchronised rx==1, then go to IDLE.
- Word assembly on each valid byte:
  - Half-word flag 0: store the byte as the high byte and set the flag.
  - Half-word flag 1: data_to_ram={high, byte}, write_enable_to_ram=1, clear the flag.
- Latency: write_enable_to_ram goes high on the clk cycle immediately after the stop-bit sample cycle and lasts exactly 1 cycle.
- address_to_ram and data_to_ram are stable during the strobe.
  - address_to_ram increments on the cycle after the strobe.
  - data_to_ram holds its value until the next write.
- Word counter:
  - After write number WORD_COUNT, load_done=1 on the same cycle the address would increment.
  - address_to_ram holds the last written address; it is not incremented and does not wrap.
- After load_done, bytes are still deserialised (so frame_error stays meaningful), but no further writes occur.
- load_done and frame_error clear only on reset.
- A break condition (rx held low) produces one frame error and then waits in WAIT_IDLE, with no repeated errors.
- A frame error does not advance the address. The next valid byte is treated as a high byte.

Test Plan:
1. Reset and idle: hold reset=0 for 5 cycles, then release with uart_rx=1 for 1000 cycles → all outputs 0, no write strobe.
2. Single word (CLKS_PER_BIT=16): send 0xAB then 0xCD → exactly one 1-cycle strobe with address 0 and data 0xABCD, asserted the cycle after the 2nd stop-bit sample; address becomes 1.
3. Full load (WORD_COUNT=4): send 8 bytes 0x00..0x07 → writes 0x0001@0, 0x0203@1, 0x0405@2, 0x0607@3. load_done=1 after the 4th write; address_to_ram stays 3. A 9th/10th byte 0xFF,0xFF → no strobe.
4. Framing error: send 0x12, then 0x34 with the stop bit forced 0, then idle, then 0x56,0x78 → frame_error=1, no write for 0x12/0x34, then one write of 0x5678 at address 0.
5. Glitch rejection: pulse uart_rx low for 3 cycles (CLKS_PER_BIT=16), then send 0x9A,0xBC → no error, single write 0x9ABC at address 0.
6. Reset mid-operation: send 0x11, assert reset during the data bits of the 2nd byte, release, then send 0x22,0x33 → single write 0x2233 at address 0; all flags 0.
